// File: rtl/bus_scheduler.sv
// Purpose : tenure-limited round-robin owner scheduler for a four-master shared bus.
// Latency : request sampled at edge N -> grant low in cycle N+1; a handover costs one dead TURN cycle.
// Backpr. : grants move only on transfer boundaries (as_ high or rdy_ low); a stalled transfer holds the bus.
//
// Optional feature: define BUS_SCHED_WATCHDOG_EN to build the stalled-transfer watchdog.
// Without it no stall counter exists, err is tied low and a stall holds the bus forever.
//
// Ports:
//   clk     system clock, all state changes on posedge
//   reset   asynchronous active-high reset
//   req_    per-master request, active-low (bit i = master i)
//   as_     address strobe from the current owner, active-low
//   rdy_    slave ready, active-low; low ends the current transfer
//   grnt_   per-master grant, registered, active-low, one-cold or all high
//   owner   index of the current or last owner, registered
//   busy    high while a master holds the grant
//   err     one-cycle watchdog pulse (0 when the watchdog is compiled out)

module bus_scheduler #(
    parameter int MAX_TENURE = 16,   // 1..31
    parameter int TIMEOUT    = 255   // 1..255, watchdog only
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req_,
    input  logic       as_,
    input  logic       rdy_,
    output logic [3:0] grnt_,
    output logic [1:0] owner,
    output logic       busy,
    output logic       err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_TURN  = 2'd2;

    // r_tenure holds (grant cycles completed) and so equals MAX_TENURE-1 in the
    // MAX_TENURE-th grant cycle; that is the first cycle a waiter may preempt.
    localparam logic [4:0] TEN_MAX = 5'(MAX_TENURE);
    localparam logic [4:0] TEN_LIM = 5'(MAX_TENURE - 1);

    logic [1:0] r_state;
    logic [1:0] r_owner;
    logic [3:0] r_grnt_;
    logic       r_busy;
    logic [4:0] r_tenure;

    logic [3:0] w_req;
    logic       w_any_req;
    logic [1:0] w_pick;
    logic [3:0] w_own_1h;
    logic       w_others;
    logic       w_boundary;
    logic       w_tenure_hit;
    logic       w_release;
    logic       w_wd_force;
    logic [1:0] w_state_nxt;
    logic [1:0] w_owner_nxt;

    assign w_req        = ~req_;
    assign w_any_req    = |w_req;
    assign w_own_1h     = 4'b0001 << r_owner;
    assign w_others     = |(w_req & ~w_own_1h);
    assign w_boundary   = as_ | ~rdy_;
    assign w_tenure_hit = (r_tenure >= TEN_LIM);

    // Round-robin pick: search owner+1, owner+2, owner+3, then owner itself.
    // Iterating from the farthest candidate down lets the nearest one win.
    always_comb begin
        w_pick = r_owner;
        for (int k = 4; k >= 1; k--) begin
            if (w_req[r_owner + 2'(k)]) begin
                w_pick = r_owner + 2'(k);
            end
        end
    end

    // Release only on a boundary: the owner dropped its request, or its
    // tenure is used up and somebody else is waiting.
    assign w_release = w_boundary &
                       (~w_req[r_owner] | (w_tenure_hit & w_others));

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_pick;
                end
            end
            S_GRANT: begin
                if (w_release || w_wd_force) begin
                    w_state_nxt = S_TURN;
                end
            end
            S_TURN: begin
                if (w_any_req) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_pick;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Grants and busy are registered from the next-state decision so they
    // line up with the state register and never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_owner <= 2'd0;
            r_grnt_ <= 4'hF;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_busy  <= (w_state_nxt == S_GRANT);
            if (w_state_nxt == S_GRANT) begin
                r_grnt_ <= ~(4'b0001 << w_owner_nxt);
            end else begin
                r_grnt_ <= 4'hF;
            end
        end
    end

    // Tenure is zero in the first grant cycle, counts up and saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tenure <= 5'd0;
        end else if (r_state != S_GRANT) begin
            r_tenure <= 5'd0;
        end else if (r_tenure != TEN_MAX) begin
            r_tenure <= r_tenure + 5'd1;
        end
    end

`ifdef BUS_SCHED_WATCHDOG_EN
    localparam logic [7:0] STALL_MAX = 8'(TIMEOUT);

    logic [7:0] r_stall;
    logic       r_err;
    logic       w_stall;

    assign w_stall = (r_state == S_GRANT) & ~as_ & rdy_;

    // err is raised on the edge where the count reaches TIMEOUT; the cycle
    // that shows err is still GRANT and is forced into TURN at its end.
    assign w_wd_force = (r_state == S_GRANT) && (r_stall == STALL_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if ((r_state != S_GRANT) || (w_state_nxt != S_GRANT)) begin
                r_stall <= 8'd0;
            end else if (w_stall) begin
                if (r_stall != STALL_MAX) begin
                    r_stall <= r_stall + 8'd1;
                end
                if (r_stall == STALL_MAX - 8'd1) begin
                    r_err <= 1'b1;
                end
            end else begin
                r_stall <= 8'd0;
            end
        end
    end

    assign err = r_err;
`else
    logic [7:0] w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT);
    assign w_wd_force       = 1'b0;
    assign err              = 1'b0;
`endif

    assign grnt_ = r_grnt_;
    assign owner = r_owner;
    assign busy  = r_busy;

endmodule
